alu_pipe: RTL

Parametrised successor to the team's fixed 8-bit ALU: operand width and multiplier latency are parameters, and it adds SUB, a multiply-accumulate with an internal accumulator, and a `ready` back-pressure signal. It sits between the operand-issue logic and the result consumer. It accepts one operation per `start`/`ready` handshake, pulses `done` once per completed operation, and holds `result` until the next completion.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mult_pipe.sv | 49 ++++
 rtl/alu_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, FSM states and
// opcode classification helpers.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_ADD    = 3'b001,
    OP_AND    = 3'b010,
    OP_XOR    = 3'b011,
    OP_MUL    = 3'b100,
    OP_SUB    = 3'b101,
    OP_MAC    = 3'b110,
    OP_CLRACC = 3'b111
  } alu_op_e;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_MULT_WAIT = 1'b1
  } alu_state_e;

  function automatic logic is_mult_op(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_MAC);
  endfunction

endpackage

// File: rtl/alu_mult_pipe.sv
// Registered WIDTHxWIDTH multiplier; product and its valid bit
// move one stage per clock, STAGES registers deep.
module alu_mult_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out_prod
);

  localparam int P = 2 * WIDTH;

  logic [STAGES-1:0][P-1:0] data_q;
  logic [STAGES-1:0][P-1:0] data_d;
  logic [STAGES-1:0]        valid_q;
  logic [STAGES-1:0]        valid_d;

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    data_d[0]  = P'(a) * P'(b);
    valid_d[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      data_d[i]  = data_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_prod  = data_q[STAGES-1];

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU top: issue FSM, wait counter, single-cycle datapath,
// accumulator and held result/done registers.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MULT_STAGES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [2*WIDTH-1:0] acc
);

  localparam int P  = 2 * WIDTH;
  localparam int CW = $clog2(MULT_STAGES);

  alu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  alu_op_e        mop_q, mop_d;
  logic           done_q, done_d;
  logic [P-1:0]   result_q, result_d;
  logic [P-1:0]   acc_q, acc_d;

  alu_op_e        op_in;
  logic           accept;
  logic           mult_go;
  logic [P-1:0]   a_ext;
  logic [P-1:0]   b_ext;
  logic [P-1:0]   prod;
  logic           prod_vld;
  logic [P-1:0]   mac_sum;

  assign op_in   = alu_op_e'(op);
  assign accept  = start && (state_q == S_IDLE);
  assign mult_go = accept && is_mult_op(op_in);
  assign a_ext   = P'(A);
  assign b_ext   = P'(B);
  assign mac_sum = acc_q + prod;

  alu_mult_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (MULT_STAGES - 1)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mult_go),
    .a         (A),
    .b         (B),
    .out_valid (prod_vld),
    .out_prod  (prod)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mop_d    = mop_q;
    done_d   = 1'b0;
    result_d = result_q;
    acc_d    = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op_in)
            OP_NOP: ;
            OP_ADD: begin
              result_d = a_ext + b_ext;
              done_d   = 1'b1;
            end
            OP_AND: begin
              result_d = a_ext & b_ext;
              done_d   = 1'b1;
            end
            OP_XOR: begin
              result_d = a_ext ^ b_ext;
              done_d   = 1'b1;
            end
            OP_SUB: begin
              result_d = a_ext - b_ext;
              done_d   = 1'b1;
            end
            OP_CLRACC: begin
              result_d = '0;
              acc_d    = '0;
              done_d   = 1'b1;
            end
            OP_MUL, OP_MAC: begin
              mop_d   = op_in;
              cnt_d   = CW'(MULT_STAGES - 2);
              state_d = S_MULT_WAIT;
            end
          endcase
        end
      end
      S_MULT_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_IDLE;
          // MAC folds into the accumulator as it stands now
          if (prod_vld) begin
            done_d = 1'b1;
            if (mop_q == OP_MAC) begin
              acc_d    = mac_sum;
              result_d = mac_sum;
            end else begin
              result_d = prod;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mop_q    <= OP_NOP;
      done_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mop_q    <= mop_d;
      done_q   <= done_d;
      result_q <= result_d;
      acc_q    <= acc_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign acc    = acc_q;

endmodule
